// File: rtl/queen_pkg.sv
// Shared types and constants for the N-queens scheduler.
package queen_pkg;

    // Width of every partial and total solution count.
    localparam int unsigned ANS_W = 32;

    // Scheduler control states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    // Number of row-0 columns needed when mirror symmetry is exploited.
    function automatic int unsigned ceil_half(input int unsigned n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/queen_pick_idle.sv
// Lowest-index priority encoder used to choose the next idle solver engine.
module queen_pick_idle #(
    parameter int unsigned W  = 2,
    parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          any_idle,
    output logic [IW-1:0] idx
);

    // Scan upward; the first set bit wins and later bits are ignored.
    always_comb begin
        any_idle = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (req[i] && !any_idle) begin
                any_idle = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/queen_sched.sv
// N-queens work scheduler: hands row-0 columns to W solver engines and sums
// their partial counts into one total.
// Optional feature macro: QUEEN_SCHED_SYMMETRY_EN (dispatch only the left half
// of row 0 and double the mirrored columns).
module queen_sched
    import queen_pkg::*;
#(
    parameter int unsigned N  = 11,
    parameter int unsigned LN = 5,
    parameter int unsigned W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [31:0]       total,
    output logic [W-1:0]      eng_go,
    output logic [W*LN-1:0]   eng_col,
    input  logic [W-1:0]      eng_valid,
    input  logic [W*32-1:0]   eng_ans
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
`ifdef QUEEN_SCHED_SYMMETRY_EN
    localparam int unsigned LIMIT = ceil_half(N);
    localparam logic [LN-1:0] HALF_C = LN'(N / 2);
`else
    localparam int unsigned LIMIT = N;
`endif
    localparam logic [LN-1:0] LIMIT_C = LN'(LIMIT);

    state_t              state_q, state_d;
    logic [ANS_W-1:0]    total_q, total_d;
    logic [LN-1:0]       next_col_q, next_col_d;
    logic [W-1:0]        eng_busy_q, eng_busy_d;
    logic [W-1:0]        go_q, go_d;
    logic [W-1:0]        go_d1_q;
    logic [W-1:0]        valid_q;
    logic [W*LN-1:0]     col_q, col_d;

    logic                any_idle;
    logic [IW-1:0]       idx;
    logic [W-1:0]        cmpl;
    logic [ANS_W-1:0]    addend;
    logic [ANS_W-1:0]    addsum;

    queen_pick_idle #(
        .W  (W),
        .IW (IW)
    ) u_pick (
        .req      (~eng_busy_q),
        .any_idle (any_idle),
        .idx      (idx)
    );

    // Valid rising while busy, masked during the launch cycle and the one after
    // so a level left high by the previous job cannot count twice.
    assign cmpl = eng_busy_q & eng_valid & ~valid_q & ~go_q & ~go_d1_q;

    // Sum every completing slice, weighted by mirror symmetry when enabled.
    always_comb begin
        addsum = '0;
        addend = '0;
        for (int unsigned i = 0; i < W; i++) begin
            addend = eng_ans[i*ANS_W +: ANS_W];
`ifdef QUEEN_SCHED_SYMMETRY_EN
            if (col_q[i*LN +: LN] < HALF_C) begin
                addend = {addend[ANS_W-2:0], 1'b0};
            end
`endif
            if (cmpl[i]) begin
                addsum = addsum + addend;
            end
        end
    end

    // Next-state, dispatch and accumulation decisions.
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        next_col_d = next_col_q;
        eng_busy_d = eng_busy_q;
        go_d       = '0;
        col_d      = col_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    total_d    = '0;
                    next_col_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                total_d    = total_q + addsum;
                eng_busy_d = eng_busy_q & ~cmpl;
                if ((next_col_q < LIMIT_C) && any_idle) begin
                    go_d[idx]              = 1'b1;
                    col_d[idx*LN +: LN]    = next_col_q;
                    eng_busy_d[idx]        = 1'b1;
                    next_col_d             = next_col_q + 1'b1;
                end else if ((next_col_q == LIMIT_C) && (eng_busy_q == '0)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            total_q    <= '0;
            next_col_q <= '0;
            eng_busy_q <= '0;
            go_q       <= '0;
            go_d1_q    <= '0;
            valid_q    <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            next_col_q <= next_col_d;
            eng_busy_q <= eng_busy_d;
            go_q       <= go_d;
            go_d1_q    <= go_q;
            valid_q    <= eng_valid;
            col_q      <= col_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == FIN);
    assign total   = total_q;
    assign eng_go  = go_q;
    assign eng_col = col_q;

endmodule

// File: tb/tb_queen_sched.sv
// Self-checking bench for queen_sched: four scheduler instances with
// different board sizes and engine counts, driven by behavioural engines.
module tb_queen_sched;

    localparam int NI = 4;
    localparam int CN[NI] = '{4, 8, 6, 5};
    localparam int CW[NI] = '{2, 3, 2, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic rs[NI];
    logic st[NI];

    logic [1:0]  go0, vld0;  logic [9:0]  col0; logic [63:0] ans0; logic busy0, done0; logic [31:0] tot0;
    logic [2:0]  go1, vld1;  logic [14:0] col1; logic [95:0] ans1; logic busy1, done1; logic [31:0] tot1;
    logic [1:0]  go2, vld2;  logic [9:0]  col2; logic [63:0] ans2; logic busy2, done2; logic [31:0] tot2;
    logic [1:0]  go3, vld3;  logic [9:0]  col3; logic [63:0] ans3; logic busy3, done3; logic [31:0] tot3;

    logic [2:0]  go_a[NI];
    logic [14:0] col_a[NI];
    logic [2:0]  vld_a[NI];
    logic [95:0] ans_a[NI];
    logic        bz[NI];
    logic        dn[NI];
    logic [31:0] tt[NI];

    assign go_a[0] = {1'b0, go0}; assign col_a[0] = {5'd0, col0};
    assign go_a[1] = go1;         assign col_a[1] = col1;
    assign go_a[2] = {1'b0, go2}; assign col_a[2] = {5'd0, col2};
    assign go_a[3] = {1'b0, go3}; assign col_a[3] = {5'd0, col3};
    assign vld0 = vld_a[0][1:0]; assign ans0 = ans_a[0][63:0];
    assign vld1 = vld_a[1];      assign ans1 = ans_a[1];
    assign vld2 = vld_a[2][1:0]; assign ans2 = ans_a[2][63:0];
    assign vld3 = vld_a[3][1:0]; assign ans3 = ans_a[3][63:0];
    assign bz[0] = busy0; assign dn[0] = done0; assign tt[0] = tot0;
    assign bz[1] = busy1; assign dn[1] = done1; assign tt[1] = tot1;
    assign bz[2] = busy2; assign dn[2] = done2; assign tt[2] = tot2;
    assign bz[3] = busy3; assign dn[3] = done3; assign tt[3] = tot3;

    queen_sched #(.N(4), .LN(5), .W(2)) u0 (
        .clk(clk), .rst(rs[0]), .start(st[0]), .busy(busy0), .done(done0), .total(tot0),
        .eng_go(go0), .eng_col(col0), .eng_valid(vld0), .eng_ans(ans0));
    queen_sched #(.N(8), .LN(5), .W(3)) u1 (
        .clk(clk), .rst(rs[1]), .start(st[1]), .busy(busy1), .done(done1), .total(tot1),
        .eng_go(go1), .eng_col(col1), .eng_valid(vld1), .eng_ans(ans1));
    queen_sched #(.N(6), .LN(5), .W(2)) u2 (
        .clk(clk), .rst(rs[2]), .start(st[2]), .busy(busy2), .done(done2), .total(tot2),
        .eng_go(go2), .eng_col(col2), .eng_valid(vld2), .eng_ans(ans2));
    queen_sched #(.N(5), .LN(5), .W(2)) u3 (
        .clk(clk), .rst(rs[3]), .start(st[3]), .busy(busy3), .done(done3), .total(tot3),
        .eng_go(go3), .eng_col(col3), .eng_valid(vld3), .eng_ans(ans3));

    // Number of row-0 columns the scheduler is expected to dispatch.
    function automatic int lim_of(input int n);
`ifdef QUEEN_SCHED_SYMMETRY_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    // Brute-force N-queens count; first>=0 pins the row-0 column.
    function automatic int qcount(input int n, input int first);
        int pos[16];
        int row, cnt, lo, hi, lr;
        bit ok;
        lo = (first >= 0) ? first : 0;
        hi = (first >= 0) ? first : n - 1;
        cnt = 0;
        row = 0;
        pos[0] = lo - 1;
        while (row >= 0) begin
            pos[row]++;
            lr = (row == 0) ? hi : n - 1;
            if (pos[row] > lr) begin
                row--;
                continue;
            end
            ok = 1'b1;
            for (int r = 0; r < row; r++) begin
                if (pos[r] == pos[row] || pos[r] - pos[row] == r - row || pos[r] - pos[row] == row - r)
                    ok = 1'b0;
            end
            if (!ok) continue;
            if (row == n - 1) cnt++;
            else begin
                row++;
                pos[row] = -1;
            end
        end
        return cnt;
    endfunction

    task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL [u%0d] %s: got %0d, expected %0d", k, nm, act, exp);
        end
    endtask

    // Model state
    bit m_run[NI];
    int m_next[NI];
    int m_hold[NI];
    int m_eng[NI][16];
    int m_simul[NI];
    int exp_tot[NI];
    bit eb_busy[NI][3];
    int eb_cnt[NI][3];
    int eb_col[NI][3];

    // Compare process plus behavioural engines, all evaluated on the falling edge.
    always @(negedge clk) begin
        bit was_run;
        int nraise, e, lat;
        for (int k = 0; k < NI; k++) begin
            if (rs[k]) begin
                m_run[k] = 1'b0;
                m_hold[k] = 0;
                m_next[k] = 0;
                vld_a[k] = '0;
                ans_a[k] = '0;
                for (int j = 0; j < 3; j++) eb_busy[k][j] = 1'b0;
            end else begin
                was_run = m_run[k];
                nraise = 0;
                if (was_run) begin
                    if (dn[k]) begin
                        chk(k, "busy_at_done", bz[k], 0);
                        chk(k, "total_at_done", tt[k], exp_tot[k]);
                        chk(k, "dispatch_count", m_next[k], lim_of(CN[k]));
                        chk(k, "go_at_done", go_a[k], 0);
                        for (int j = 0; j < CW[k]; j++) chk(k, "engine_idle_at_done", eb_busy[k][j], 0);
                        m_run[k] = 1'b0;
                        m_hold[k] = tt[k];
                    end else begin
                        chk(k, "busy_run", bz[k], 1);
                    end
                end else begin
                    chk(k, "busy_idle", bz[k], 0);
                    chk(k, "done_idle", dn[k], 0);
                    chk(k, "total_held", tt[k], m_hold[k]);
                    chk(k, "go_idle", go_a[k], 0);
                end
                // column must stay put for every engine still working
                for (int j = 0; j < CW[k]; j++)
                    if (eb_busy[k][j]) chk(k, "col_stable", col_a[k][j*5 +: 5], eb_col[k][j]);
                // engines progress
                for (int j = 0; j < CW[k]; j++) begin
                    if (eb_busy[k][j]) begin
                        eb_cnt[k][j]--;
                        if (eb_cnt[k][j] <= 0) begin
                            eb_busy[k][j] = 1'b0;
                            vld_a[k][j] = 1'b1;
                            ans_a[k][j*32 +: 32] = 32'(qcount(CN[k], eb_col[k][j]));
                            nraise++;
                        end
                    end
                end
                if (nraise > 1) m_simul[k]++;
                // dispatch
                if (was_run && !dn[k] && go_a[k] != 0) begin
                    chk(k, "go_onehot", $countones(go_a[k]), 1);
                    e = 0;
                    for (int j = 2; j >= 0; j--) if (go_a[k][j]) e = j;
                    chk(k, "go_engine_idle", eb_busy[k][e], 0);
                    chk(k, "go_col", col_a[k][e*5 +: 5], m_next[k]);
                    chk(k, "go_within_limit", m_next[k] < lim_of(CN[k]), 1);
                    case (k)
                        0: lat = 5;
                        1: lat = int'($urandom_range(40, 3));
                        2: lat = 5 - e;
                        default: lat = 3 + e;
                    endcase
                    m_eng[k][m_next[k] & 15] = e;
                    eb_busy[k][e] = 1'b1;
                    eb_col[k][e] = m_next[k];
                    eb_cnt[k][e] = lat;
                    vld_a[k][e] = 1'b0;
                    m_next[k]++;
                end
                if (!was_run && st[k]) begin
                    m_run[k] = 1'b1;
                    m_next[k] = 0;
                end
            end
        end
    end

    task automatic pulse_start(input int k);
        @(posedge clk); #1 st[k] = 1'b1;
        @(posedge clk); #1 st[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int lit, input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (dn[k]) got = 1'b1;
        end
        if (!got) chk(k, "done_timeout", 0, 1);
        @(posedge clk); #1;
        chk(k, nm, tt[k], lit);
    endtask

    initial begin
        int eng_exp[4];
        eng_exp = '{0, 1, 0, 1};
        for (int k = 0; k < NI; k++) begin
            rs[k] = 1'b1;
            st[k] = 1'b0;
            exp_tot[k] = qcount(CN[k], -1);
            m_simul[k] = 0;
        end
        chk(0, "model_n4", qcount(4, -1), 2);
        chk(1, "model_n8", exp_tot[1], 92);
        chk(2, "model_n6_col0", qcount(6, 0), 0);
        chk(3, "model_n5", exp_tot[3], 10);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk(k, "reset_busy", bz[k], 0);
            chk(k, "reset_done", dn[k], 0);
            chk(k, "reset_total", tt[k], 0);
            chk(k, "reset_go", go_a[k], 0);
            chk(k, "reset_col", col_a[k], 0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) rs[k] = 1'b0;

        // N=4, two engines, fixed latency
        pulse_start(0);
        wait_done(0, 2, "n4_total");
        for (int c = 0; c < lim_of(4); c++) chk(0, "n4_engine_order", m_eng[0][c], eng_exp[c]);

        // N=8, three engines, random latency
        pulse_start(1);
        wait_done(1, 92, "n8_total");

        // N=6, engines finishing together
        pulse_start(2);
        wait_done(2, 4, "n6_total");
        chk(2, "n6_same_cycle_completion", m_simul[2] > 0, 1);

        // start during RUN ignored; rerun clears the total
        pulse_start(2);
        repeat (3) @(posedge clk);
        pulse_start(2);
        wait_done(2, 4, "n6_total_ignore_start");
        pulse_start(2);
        wait_done(2, 4, "n6_total_rerun");

        // reset in the middle of a run
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1 chk(0, "midrun_busy", bz[0], 1);
        rs[0] = 1'b1;
        #1;
        chk(0, "midrun_reset_busy", bz[0], 0);
        chk(0, "midrun_reset_done", dn[0], 0);
        chk(0, "midrun_reset_go", go_a[0], 0);
        chk(0, "midrun_reset_total", tt[0], 0);
        repeat (2) @(posedge clk);
        #1 rs[0] = 1'b0;
        pulse_start(0);
        wait_done(0, 2, "n4_total_after_reset");

        // N=5, odd board
        pulse_start(3);
        wait_done(3, 10, "n5_total");

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
